reg_port_arbiter: RTL

// Shares the single register-file access port (ADDR/WEN/REN/WD/RD) between two requesters:

---
 rtl/reg_port_arbiter_if.sv | 40 ++++
 rtl/reg_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_port_arbiter_if.sv
// Bundle for the two requester ports and the shared register-file port.
// The arbiter takes the slave view; requesters and the register file take the master view.
interface reg_port_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 8
);
    // Requester port 0 (SPI command path)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wd0;
    logic          ack0;
    logic [DW-1:0] rd0;
    // Requester port 1 (internal/MCU master)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd1;
    logic          ack1;
    logic [DW-1:0] rd1;
    // Register-file access port
    logic [AW-1:0] rf_addr;
    logic          rf_wen;
    logic          rf_ren;
    logic [DW-1:0] rf_wd;
    logic [DW-1:0] rf_rd;
    // Status
    logic          gnt;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, rf_rd,
        output ack0, rd0, ack1, rd1, rf_addr, rf_wen, rf_ren, rf_wd, gnt, busy
    );

    modport master (
        output req0, we0, addr0, wd0, req1, we1, addr1, wd1, rf_rd,
        input  ack0, rd0, ack1, rd1, rf_addr, rf_wen, rf_ren, rf_wd, gnt, busy
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Two-port arbiter for the single register-file access port.
// Handshake: a requester raises reqN with weN/addrN/wdN stable and holds it until
// it samples ackN high on a rising edge; ackN is a one-cycle pulse, rdN is valid
// with it and held until that port's next read. Each access walks
// IDLE -> STROBE -> WAIT -> ACK, so one access completes every four cycles.
// Every output is registered; no input reaches an output combinationally.
module reg_port_arbiter #(
    parameter int AW   = 7,
    parameter int DW   = 8,
    parameter int PRIO = 0
) (
    input  logic                clk,
    input  logic                rstn,
    reg_port_arbiter_if.slave   bus,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;      // port served last; 1 after reset so port 0 wins first tie
    logic          we_q, we_d;          // latched direction of the access in flight
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;
    logic          rf_wen_q, rf_wen_d;
    logic          rf_ren_q, rf_ren_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          gnt_q, gnt_d;
    logic          busy_q, busy_d;

    logic          any_req;
    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wd;

    // Pick the winner among the current requests and mux its command fields
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win = (PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            win = ~bus.req0;
        end
        win_we   = win ? bus.we1   : bus.we0;
        win_addr = win ? bus.addr1 : bus.addr0;
        win_wd   = win ? bus.wd1   : bus.wd0;
    end

    // State and output registers; reset aborts any access without ack or strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            rf_addr_q <= '0;
            rf_wd_q   <= '0;
            rf_wen_q  <= 1'b0;
            rf_ren_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            gnt_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            we_q      <= we_d;
            rf_addr_q <= rf_addr_d;
            rf_wd_q   <= rf_wd_d;
            rf_wen_q  <= rf_wen_d;
            rf_ren_q  <= rf_ren_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
        end
    end

    // Next state: leave IDLE on any request, then step through the fixed sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT;
            S_WAIT:   state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next output values; computed one cycle ahead so every output leaves a flop
    always_comb begin
        last_d    = last_q;
        we_d      = we_q;
        rf_addr_d = rf_addr_q;
        rf_wd_d   = rf_wd_q;
        rf_wen_d  = 1'b0;
        rf_ren_d  = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        gnt_d     = gnt_q;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d     = win;
                    last_d    = win;
                    we_d      = win_we;
                    rf_addr_d = win_addr;
                    rf_wd_d   = win_wd;
                    rf_wen_d  = win_we;
                    rf_ren_d  = ~win_we;
                end
            end
            S_WAIT: begin
                // rf_rd is valid this cycle (one after the read strobe)
                if (!we_q) begin
                    if (gnt_q) rd1_d = bus.rf_rd;
                    else       rd0_d = bus.rf_rd;
                end
                if (gnt_q) ack1_d = 1'b1;
                else       ack0_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_wd   = rf_wd_q;
    assign bus.rf_wen  = rf_wen_q;
    assign bus.rf_ren  = rf_ren_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rd0     = rd0_q;
    assign bus.rd1     = rd1_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign fsm_state   = state_q;

endmodule
